// File: rtl/color_decoder_pkg.sv
// Shared colour definitions for the colour decoder: the RGB565 pixel type,
// the sixteen named palette colours and the default palette table used by
// both the reset path of the writable palette and the constant ROM.
package color_decoder_pkg;

  typedef logic [15:0] rgb565_t;
  typedef rgb565_t     palette_t [16];

  localparam rgb565_t BLACK      = 16'h0000;
  localparam rgb565_t NAVY       = 16'h000F;
  localparam rgb565_t DARK_GREEN = 16'h03E0;
  localparam rgb565_t DARK_CYAN  = 16'h03EF;
  localparam rgb565_t MAROON     = 16'h7800;
  localparam rgb565_t PURPLE     = 16'h780F;
  localparam rgb565_t OLIVE      = 16'h7BE0;
  localparam rgb565_t LIGHT_GREY = 16'hC618;
  localparam rgb565_t DARK_GREY  = 16'h7BEF;
  localparam rgb565_t BLUE       = 16'h001F;
  localparam rgb565_t GREEN      = 16'h07E0;
  localparam rgb565_t CYAN       = 16'h07FF;
  localparam rgb565_t RED        = 16'hF800;
  localparam rgb565_t MAGENTA    = 16'hF81F;
  localparam rgb565_t YELLOW     = 16'hFFE0;
  localparam rgb565_t WHITE      = 16'hFFFF;

  // Element 0 is palette index 0.
  localparam palette_t DEFAULT_PALETTE = '{
    BLACK, NAVY, DARK_GREEN, DARK_CYAN,
    MAROON, PURPLE, OLIVE, LIGHT_GREY,
    DARK_GREY, BLUE, GREEN, CYAN,
    RED, MAGENTA, YELLOW, WHITE
  };

  function automatic rgb565_t default_color(input logic [3:0] idx);
    return DEFAULT_PALETTE[idx];
  endfunction

endpackage

// File: rtl/color_palette_regs.sv
// Palette storage for the colour decoder. Combinational read port; the
// caller registers the result, so a write and a read of the same entry in
// one cycle returns the pre-write value.
// Macro COLOR_DECODER_PALETTE_WR_EN: defined -> 16x16 register file with a
// write port and asynchronous restore to the default palette; undefined ->
// constant ROM holding the default palette (no clock, reset or write port).
module color_palette_regs
  import color_decoder_pkg::*;
(
`ifdef COLOR_DECODER_PALETTE_WR_EN
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we,
  input  logic [3:0] wr_addr,
  input  rgb565_t   wr_data,
`endif
  input  logic [3:0] rd_addr,
  output rgb565_t   rd_data
);

`ifdef COLOR_DECODER_PALETTE_WR_EN
  rgb565_t mem [16];

  // Register file: reset restores defaults, otherwise one write per strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= DEFAULT_PALETTE[i];
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];
`else
  assign rd_data = default_color(rd_addr);
`endif

endmodule

// File: rtl/color_decoder.sv
// Colour decoder: maps a 4-bit pixel colour index to an RGB565 word through
// a 16-entry palette with one cycle of latency. out_valid follows in_valid
// one cycle later; Output holds its last value between valid pixels.
// Macro COLOR_DECODER_PALETTE_WR_EN adds the pal_we/pal_addr/pal_data write
// port and makes the palette writable; without it the palette is a ROM.
module color_decoder
  import color_decoder_pkg::*;
#(
  parameter logic [3:0] RESET_INDEX = 4'hF
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Input,
  input  logic       in_valid,
`ifdef COLOR_DECODER_PALETTE_WR_EN
  input  logic       pal_we,
  input  logic [3:0] pal_addr,
  input  rgb565_t    pal_data,
`endif
  output rgb565_t    Output,
  output logic       out_valid
);

  rgb565_t color_p0;
  rgb565_t color_p1;
  logic    vld_p1;

  color_palette_regs u_palette (
`ifdef COLOR_DECODER_PALETTE_WR_EN
    .clk     (CLK),
    .rst_n   (Reset),
    .we      (pal_we),
    .wr_addr (pal_addr),
    .wr_data (pal_data),
`endif
    .rd_addr (Input),
    .rd_data (color_p0)
  );

  // p0 -> p1: register the looked-up colour on valid pixels; reset shows the
  // reset colour and drops any pixel in flight.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      color_p1 <= default_color(RESET_INDEX);
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        color_p1 <= color_p0;
      end
    end
  end

  assign Output    = color_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_color_decoder.sv
// Self-checking bench for color_decoder. Expected colours come from a local
// palette model and are queued when a pixel is driven, then popped when the
// decoder presents it. Palette-write scenarios are built only when
// COLOR_DECODER_PALETTE_WR_EN is defined.
module tb_color_decoder;

  localparam logic [15:0] DEFAULTS [16] = '{
    16'h0000, 16'h000F, 16'h03E0, 16'h03EF,
    16'h7800, 16'h780F, 16'h7BE0, 16'hC618,
    16'h7BEF, 16'h001F, 16'h07E0, 16'h07FF,
    16'hF800, 16'hF81F, 16'hFFE0, 16'hFFFF
  };

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Input = 4'h0;
  logic        in_valid = 1'b0;
  logic [15:0] Output;
  logic        out_valid;
`ifdef COLOR_DECODER_PALETTE_WR_EN
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = 4'h0;
  logic [15:0] pal_data = 16'h0000;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] model [16];
  logic [15:0] exp_q [$];
  logic [15:0] last_out;

  color_decoder #(.RESET_INDEX(4'hF)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Input     (Input),
    .in_valid  (in_valid),
`ifdef COLOR_DECODER_PALETTE_WR_EN
    .pal_we    (pal_we),
    .pal_addr  (pal_addr),
    .pal_data  (pal_data),
`endif
    .Output    (Output),
    .out_valid (out_valid)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_model();
    for (int i = 0; i < 16; i++) model[i] = DEFAULTS[i];
  endtask

  // Drive one cycle of stimulus (called at a falling edge), queue the
  // expected colour for valid pixels, and return at the next falling edge.
  task automatic drive_cycle(input logic v, input logic [3:0] idx);
    in_valid = v;
    Input    = idx;
    if (v) exp_q.push_back(model[idx]);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    #1 Reset = 1'b0;
    #2;
    tests_run++;
    if (Output !== 16'hFFFF || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: Output=%h out_valid=%b, required FFFF/0", Output, out_valid);
    end
    repeat (3) @(negedge CLK);
    tests_run++;
    if (Output !== 16'hFFFF || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_held: Output=%h out_valid=%b, required FFFF/0", Output, out_valid);
    end
    Reset = 1'b1;
    repeat (3) drive_cycle(1'b0, 4'h0);
    tests_run++;
    if (Output !== 16'hFFFF || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: Output=%h out_valid=%b, required FFFF/0", Output, out_valid);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] exp;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 4'(i));
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      tests_run++;
      if (out_valid !== 1'b1 || Output !== exp) begin
        tests_failed++;
        $display("FAIL sweep_idx%0d: Output=%h out_valid=%b, required %h/1", i, Output, out_valid, exp);
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] exp;
    drive_cycle(1'b1, 4'h9);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    tests_run++;
    if (out_valid !== 1'b1 || Output !== exp || Output !== 16'h001F) begin
      tests_failed++;
      $display("FAIL hold_load: Output=%h out_valid=%b, required 001F/1", Output, out_valid);
    end
    drive_cycle(1'b0, 4'h4);
    tests_run++;
    if (out_valid !== 1'b0 || Output !== 16'h001F) begin
      tests_failed++;
      $display("FAIL hold_idle: Output=%h out_valid=%b, required 001F/0", Output, out_valid);
    end
    drive_cycle(1'b0, 4'hC);
    tests_run++;
    if (out_valid !== 1'b0 || Output !== 16'h001F) begin
      tests_failed++;
      $display("FAIL hold_idle2: Output=%h out_valid=%b, required 001F/0", Output, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic       v;
    logic [3:0] idx;
    logic [15:0] exp;
    last_out = Output;
    for (int n = 0; n < 40; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      idx = 4'($urandom_range(0, 15));
      drive_cycle(v, idx);
      if (v) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        last_out = exp;
      end else begin
        exp = last_out;
      end
      tests_run++;
      if (out_valid !== v || Output !== exp) begin
        tests_failed++;
        $display("FAIL b2b_%0d idx=%h v=%b: Output=%h out_valid=%b, required %h/%b",
                 n, idx, v, Output, out_valid, exp, v);
      end
    end
  endtask

`ifdef COLOR_DECODER_PALETTE_WR_EN
  task automatic test_palette_write();
    logic [15:0] exp;
    pal_we   = 1'b1;
    pal_addr = 4'h3;
    pal_data = 16'hABCD;
    in_valid = 1'b1;
    Input    = 4'h3;
    exp_q.push_back(model[3]);
    @(posedge CLK);
    model[3] = 16'hABCD;
    @(negedge CLK);
    pal_we = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    tests_run++;
    if (out_valid !== 1'b1 || Output !== exp || Output !== 16'h03EF) begin
      tests_failed++;
      $display("FAIL wr_same_cycle: Output=%h out_valid=%b, required 03EF/1", Output, out_valid);
    end
    drive_cycle(1'b1, 4'h3);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    tests_run++;
    if (out_valid !== 1'b1 || Output !== exp || Output !== 16'hABCD) begin
      tests_failed++;
      $display("FAIL wr_next_lookup: Output=%h out_valid=%b, required ABCD/1", Output, out_valid);
    end
    drive_cycle(1'b1, 4'h2);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    tests_run++;
    if (Output !== exp) begin
      tests_failed++;
      $display("FAIL wr_neighbour: Output=%h, required %h", Output, exp);
    end
  endtask
`endif

  task automatic test_reset_midstream();
    logic [15:0] exp;
    in_valid = 1'b1;
    Input    = 4'h5;
    #2 Reset = 1'b0;
    #1;
    tests_run++;
    if (Output !== 16'hFFFF || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_async: Output=%h out_valid=%b, required FFFF/0", Output, out_valid);
    end
    @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if (Output !== 16'hFFFF || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_held: Output=%h out_valid=%b, required FFFF/0", Output, out_valid);
    end
    exp_q.delete();
    reset_model();
    in_valid = 1'b0;
    Reset    = 1'b1;
    drive_cycle(1'b0, 4'h5);
    tests_run++;
    if (Output !== 16'hFFFF || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_discard: Output=%h out_valid=%b, required FFFF/0", Output, out_valid);
    end
    drive_cycle(1'b1, 4'h3);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    tests_run++;
    if (out_valid !== 1'b1 || Output !== exp || Output !== 16'h03EF) begin
      tests_failed++;
      $display("FAIL mid_reset_restore: Output=%h out_valid=%b, required 03EF/1", Output, out_valid);
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_sweep();
    test_hold();
    test_back_to_back();
`ifdef COLOR_DECODER_PALETTE_WR_EN
    test_palette_write();
`endif
    test_reset_midstream();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
